// File: rtl/adder_vector_gen.sv
// Operand vector source for the adder benches: emits {cin,a,b} over valid/ready,
// with random (Galois LFSR), walking-one, corner and counting patterns.
module adder_vector_gen #(
  parameter int unsigned n         = 128,
  parameter int unsigned file_size = 30000,
  parameter logic [63:0] seed      = 64'h0123456789ABCDEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         ready,
  output logic         valid,
  output logic         cin,
  output logic [n-1:0] a,
  output logic [n-1:0] b,
  output logic [31:0]  vec_idx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned LANES    = (n + 63) / 64;
  localparam int unsigned WW       = (n > 1) ? $clog2(n) : 1;
  localparam logic [63:0] SEED_EFF = (seed == 64'd0) ? 64'd1 : seed;
  localparam logic [63:0] POLY     = 64'hD800000000000000;
  localparam logic [63:0] GOLD     = 64'h9E3779B97F4A7C15;
  localparam logic [31:0] LAST     = 32'(file_size - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [63:0]    lfsr_q, lfsr_d;
  logic [1:0]     mode_q, mode_d;
  logic [31:0]    idx_q, idx_d;
  logic [WW-1:0]  walk_q, walk_d;
  logic           cin_q, cin_d;
  logic [n-1:0]   a_q, a_d, b_q, b_d;

  // generator inputs, muxed so a single pattern generator serves load and advance
  logic           load;
  logic [1:0]     g_mode;
  logic [31:0]    g_idx;
  logic [63:0]    g_lfsr;
  logic [WW-1:0]  g_walk;
  logic [2*n:0]   g_vec;
  logic           xfer;

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
  endfunction

  function automatic logic [2*n:0] gen_vec(input logic [1:0]    md,
                                           input logic [31:0]   k,
                                           input logic [63:0]   lf,
                                           input logic [WW-1:0] walk);
    logic [LANES*64-1:0] aw, bw;
    logic [n-1:0]        va, vb;
    logic                vc;
    aw = '0;
    bw = '0;
    va = '0;
    vb = '0;
    vc = 1'b0;
    unique case (md)
      2'd0: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          aw[i*64 +: 64] = lf ^ (64'(i) * GOLD);
          bw[i*64 +: 64] = {lf[31:0], lf[63:32]} ^ (64'(i) * GOLD);
        end
        va = aw[n-1:0];
        vb = bw[n-1:0];
        vc = lf[0];
      end
      2'd1: begin
        va = n'(1) << walk;
        vb = '1;
      end
      2'd2: begin
        unique case (k[1:0])
          2'd0: ;
          2'd1: begin vc = 1'b1; va = '1; end
          2'd2: begin vc = 1'b1; va = '1; vb = '1; end
          2'd3: begin va = '1; vb = n'(1); end
        endcase
      end
      2'd3: begin
        va = n'(k);
        vb = ~va;
        vc = k[0];
      end
    endcase
    return {vc, va, vb};
  endfunction

  assign xfer  = (state_q == S_RUN) && ready;
  assign g_vec = gen_vec(g_mode, g_idx, g_lfsr, g_walk);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    walk_d  = walk_q;
    cin_d   = cin_q;
    a_d     = a_q;
    b_d     = b_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          lfsr_d  = SEED_EFF;
          mode_d  = mode;
          idx_d   = '0;
          walk_d  = '0;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + 32'd1;
            walk_d = (walk_q == WW'(n - 1)) ? '0 : walk_q + 1'b1;
            if (mode_q == 2'd0) lfsr_d = lfsr_step(lfsr_q);
            load = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    g_mode = mode_d;
    g_idx  = idx_d;
    g_lfsr = lfsr_d;
    g_walk = walk_d;
    if (load) {cin_d, a_d, b_d} = g_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      mode_q  <= '0;
      idx_q   <= '0;
      walk_q  <= '0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      walk_q  <= walk_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign valid   = (state_q == S_RUN);
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign cin     = cin_q;
  assign a       = a_q;
  assign b       = b_q;
  assign vec_idx = idx_q;

endmodule

// File: tb/tb_adder_vector_gen.sv
// Bench for adder_vector_gen: a short-run n=8 instance and a full-length n=128
// instance, checked against a reference model through an expected-vector queue.
module tb_adder_vector_gen;

  localparam int unsigned SN    = 8;
  localparam int unsigned SFS   = 4;
  localparam logic [63:0] SSEED = 64'h0;
  localparam int unsigned LN    = 128;
  localparam int unsigned LFS   = 30000;
  localparam logic [63:0] LSEED = 64'h0123456789ABCDEF;
  localparam logic [63:0] GOLD  = 64'h9E3779B97F4A7C15;

  typedef struct {
    logic [31:0]  idx;
    logic         cin;
    logic [127:0] a;
    logic [127:0] b;
  } vec_t;

  vec_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] mode = 2'd0;

  logic           s_start, s_ready, s_valid, s_cin, s_busy, s_done;
  logic [SN-1:0]  s_a, s_b;
  logic [31:0]    s_idx;
  logic           l_start, l_ready, l_valid, l_cin, l_busy, l_done;
  logic [LN-1:0]  l_a, l_b;
  logic [31:0]    l_idx;

  assign s_start = start & ~sel;
  assign s_ready = ready & ~sel;
  assign l_start = start & sel;
  assign l_ready = ready & sel;

  adder_vector_gen #(.n(SN), .file_size(SFS), .seed(SSEED)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .mode(mode), .ready(s_ready),
    .valid(s_valid), .cin(s_cin), .a(s_a), .b(s_b), .vec_idx(s_idx),
    .busy(s_busy), .done(s_done)
  );

  adder_vector_gen #(.n(LN), .file_size(LFS), .seed(LSEED)) dut_l (
    .clk(clk), .rst(rst), .start(l_start), .mode(mode), .ready(l_ready),
    .valid(l_valid), .cin(l_cin), .a(l_a), .b(l_b), .vec_idx(l_idx),
    .busy(l_busy), .done(l_done)
  );

  logic         o_valid, o_cin, o_busy, o_done;
  logic [127:0] o_a, o_b;
  logic [31:0]  o_idx;

  always_comb begin
    if (sel) begin
      o_valid = l_valid; o_cin = l_cin; o_busy = l_busy; o_done = l_done;
      o_a = l_a; o_b = l_b; o_idx = l_idx;
    end else begin
      o_valid = s_valid; o_cin = s_cin; o_busy = s_busy; o_done = s_done;
      o_a = 128'(s_a); o_b = 128'(s_b); o_idx = s_idx;
    end
  end

  function automatic logic [63:0] lfsr_next(input logic [63:0] l);
    logic fb;
    fb = l[0];
    return {fb, l[63:1]} ^ (64'(fb) << 62) ^ (64'(fb) << 60) ^ (64'(fb) << 59);
  endfunction

  function automatic vec_t model(input int unsigned nn, input logic [1:0] md,
                                 input int unsigned k, input logic [63:0] lf);
    vec_t         v;
    logic [127:0] m;
    logic [63:0]  rot;
    m     = (nn >= 128) ? '1 : ((128'd1 << nn) - 128'd1);
    rot   = {lf[31:0], lf[63:32]};
    v.idx = k;
    v.cin = 1'b0;
    v.a   = '0;
    v.b   = '0;
    case (md)
      2'd0: begin v.a = {lf ^ GOLD, lf}; v.b = {rot ^ GOLD, rot}; v.cin = lf[0]; end
      2'd1: begin v.a = 128'd1 << (k % nn); v.b = '1; end
      2'd2: begin
        case (k % 4)
          1: begin v.cin = 1'b1; v.a = '1; end
          2: begin v.cin = 1'b1; v.a = '1; v.b = '1; end
          3: begin v.a = '1; v.b = 128'd1; end
          default: ;
        endcase
      end
      default: begin v.a = 128'(k); v.b = ~v.a; v.cin = k[0]; end
    endcase
    v.a = v.a & m;
    v.b = v.b & m;
    return v;
  endfunction

  task automatic push_run(input logic [1:0] md, input logic [63:0] sd,
                          input int unsigned nn, input int unsigned count);
    logic [63:0] lf;
    lf = (sd == 64'd0) ? 64'd1 : sd;
    for (int unsigned k = 0; k < count; k++) begin
      q.push_back(model(nn, md, k, lf));
      if (md == 2'd0) lf = lfsr_next(lf);
    end
  endtask

  task automatic start_run(input logic s, input logic [1:0] md);
    @(negedge clk);
    sel = s; mode = md; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_idx !== 32'd0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: valid=%b idx=%0d done=%b busy=%b, expected 1 0 0 1",
               o_valid, o_idx, o_done, o_busy);
    end
  endtask

  // Every cycle with a vector on the outputs is compared against the queue head,
  // so held (non-transfer) cycles are checked for stability too.
  task automatic drain(input int budget, input int ready_pct, input int stall_idx,
                       input int stall_cnt, input int start_idx);
    vec_t exp, last;
    int   cyc = 0;
    int   stall = stall_cnt;
    mode = ~mode;
    while (q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (start_idx >= 0) && o_valid && (o_idx == 32'(start_idx));
      if (stall_idx >= 0 && o_valid && o_idx == 32'(stall_idx) && stall > 0) begin
        ready = 1'b0;
        stall--;
      end else begin
        ready = ($urandom_range(99) < ready_pct);
      end
      exp = q[0];
      checks++;
      if (o_valid !== 1'b1 || o_idx !== exp.idx || o_cin !== exp.cin ||
          o_a !== exp.a || o_b !== exp.b) begin
        errors++;
        $display("FAIL vector: valid=%b idx=%0d cin=%b a=%h b=%h, expected valid=1 idx=%0d cin=%b a=%h b=%h",
                 o_valid, o_idx, o_cin, o_a, o_b, exp.idx, exp.cin, exp.a, exp.b);
      end
      if (ready) last = q.pop_front();
    end
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d vectors left, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
    start = 1'b0;
    ready = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_idx !== last.idx ||
        o_a !== last.a || o_b !== last.b || o_cin !== last.cin) begin
      errors++;
      $display("FAIL run_end: done=%b valid=%b busy=%b idx=%0d cin=%b a=%h b=%h, expected 1 0 0 idx=%0d cin=%b a=%h b=%h",
               o_done, o_valid, o_busy, o_idx, o_cin, o_a, o_b, last.idx, last.cin, last.a, last.b);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0 || s_cin !== 1'b0 ||
        s_a !== '0 || s_b !== '0 || s_idx !== 32'd0) begin
      errors++;
      $display("FAIL reset_small: valid=%b busy=%b done=%b cin=%b a=%h b=%h idx=%0d, expected all zero",
               s_valid, s_busy, s_done, s_cin, s_a, s_b, s_idx);
    end
    checks++;
    if (l_valid !== 1'b0 || l_busy !== 1'b0 || l_done !== 1'b0 || l_cin !== 1'b0 ||
        l_a !== '0 || l_b !== '0 || l_idx !== 32'd0) begin
      errors++;
      $display("FAIL reset_long: valid=%b busy=%b done=%b cin=%b a=%h b=%h idx=%0d, expected all zero",
               l_valid, l_busy, l_done, l_cin, l_a, l_b, l_idx);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_valid !== 1'b0 || s_done !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: valid=%b done=%b busy=%b, expected 0 0 0", s_valid, s_done, s_busy);
    end
  endtask

  task automatic test_corner;
    push_run(2'd2, SSEED, SN, SFS);
    start_run(1'b0, 2'd2);
    drain(50, 100, -1, 0, -1);
  endtask

  task automatic test_walk_stall;
    push_run(2'd1, SSEED, SN, SFS);
    start_run(1'b0, 2'd1);
    drain(50, 100, 2, 5, -1);
  endtask

  task automatic test_lfsr_seed0;
    for (int r = 0; r < 2; r++) begin
      push_run(2'd0, SSEED, SN, SFS);
      start_run(1'b0, 2'd0);
      checks++;
      if (s_a !== 8'h01 || s_cin !== 1'b1) begin
        errors++;
        $display("FAIL lfsr_seed0 run%0d: a=%h cin=%b, expected a=01 cin=1", r, s_a, s_cin);
      end
      drain(50, 60, -1, 0, -1);
    end
  endtask

  task automatic test_start_ignored;
    push_run(2'd3, SSEED, SN, SFS);
    start_run(1'b0, 2'd3);
    drain(50, 100, -1, 0, 1);
    push_run(2'd3, SSEED, SN, SFS);
    start_run(1'b0, 2'd3);
    drain(50, 100, -1, 0, 3);
    repeat (2) @(negedge clk);
    checks++;
    if (s_done !== 1'b1 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_on_last: done=%b valid=%b, expected done=1 valid=0", s_done, s_valid);
    end
    push_run(2'd3, SSEED, SN, SFS);
    start_run(1'b0, 2'd3);
    drain(50, 100, -1, 0, -1);
  endtask

  task automatic test_reset_midrun;
    vec_t exp;
    push_run(2'd0, LSEED, LN, 3);
    start_run(1'b1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ready = 1'b1;
      exp = q.pop_front();
      checks++;
      if (o_valid !== 1'b1 || o_idx !== exp.idx || o_cin !== exp.cin ||
          o_a !== exp.a || o_b !== exp.b) begin
        errors++;
        $display("FAIL random_lanes: idx=%0d cin=%b a=%h b=%h, expected idx=%0d cin=%b a=%h b=%h",
                 o_idx, o_cin, o_a, o_b, exp.idx, exp.cin, exp.a, exp.b);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_a !== '0 || o_b !== '0 || o_idx !== 32'd0) begin
      errors++;
      $display("FAIL reset_midrun: valid=%b busy=%b a=%h b=%h idx=%0d, expected all zero",
               o_valid, o_busy, o_a, o_b, o_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: valid=%b busy=%b done=%b, expected 0 0 0", o_valid, o_busy, o_done);
    end
    q.delete();
  endtask

  task automatic test_count_long;
    push_run(2'd3, LSEED, LN, LFS);
    start_run(1'b1, 2'd3);
    drain(60000, 75, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_corner();
    test_walk_stall();
    test_lfsr_seed0();
    test_start_ignored();
    test_reset_midrun();
    test_count_long();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
